gpio_local_ram: RTL and testbench
=================================

# gpio_local_ram

Memory-mapped peripheral subsystem on the CPU data/instruction bus of the SoC: an on-chip byte-writable local RAM plus an NR_GPIOS-bit GPIO port, behind a shared address decoder and response multiplexer. It accepts every command immediately. It returns read data with fixed latency per target, and answers reads to unmapped space with zero.

## Interface
- LOCAL_RAM_SIZE_KB, 8: RAM size in KiB; WORDS = LOCAL_RAM_SIZE_KB*256 32-bit words, power of two.
- NR_GPIOS, 8: GPIO width, 1..32.
- clk  input  1  single clock, all logic on rising edge.
- reset_  input  1  reset; asynchronous, active-low.
- mem_cmd_valid  input  1  command strobe, one command per asserted cycle.
- mem_cmd_ready  output  1  tied to 1.
- mem_cmd_wr  input  1  1 = write, 0 = read.
- mem_cmd_addr  input  32  byte address, word-aligned.
- mem_cmd_wdata  input  32  write data.
- mem_cmd_be  input  4  byte enables for writes; bit i = wdata[8i+7:8i].
- mem_rsp_ready  output  1  one-cycle pulse marking valid read data.
- mem_rsp_rdata  output  32  read data, valid when mem_rsp_ready = 1.
- gpio_oe  output  NR_GPIOS  per-pin output enable.
- gpio_do  output  NR_GPIOS  per-pin output value.
- gpio_di  input  NR_GPIOS  pin input values, asynchronous.

## Operation
- Decode: RAM if addr < LOCAL_RAM_SIZE_KB*1024. GPIO if addr[31:12] == 20'hF0000. Otherwise void.
- RAM write: the bytes selected by be are updated at addr[log2(WORDS)+1:2]. be = 0 writes nothing. RAM contents are not reset.
- RAM read: returns the full 32-bit word.
- GPIO map, using offset addr[11:0]:
  - 0x000 DO: read/write, drives gpio_do.
  - 0x004 OE: read/write, drives gpio_oe.
  - 0x008 DI: read-only, sampled gpio_di.
  - Other offsets read 0. Writes to them are ignored.
- GPIO writes ignore be and use wdata[NR_GPIOS-1:0]. Upper read bits return 0.
- Void: writes are ignored. Reads return 0.
- Read responses are built by OR-combining per-target data, each gated by its own ready pulse. A single global response-select register is not used.
- Requester keeps at most one read outstanding: no new read until mem_rsp_ready. Writes may be issued in any cycle, including while a read is outstanding, and do not disturb the pending response.

## Timing
- Reset values: gpio_oe = 0, gpio_do = 0, mem_rsp_ready = 0, mem_rsp_rdata = 0, DI sample registers = 0.
- RAM read latency: command in cycle N, rsp_ready and data in cycle N+2. Stage 1 is the RAM array read; stage 2 is the output register.
- GPIO and void read latency: command in cycle N, response in cycle N+1.
- Writes take effect at the end of the command cycle:
  - A read issued in the next cycle returns the new data.
  - gpio_do/gpio_oe change in cycle N+1.
- DI: pins pass through the synchronizer before reads see them; see Configuration.
- Reset asserted mid-read: the pending response is dropped, with no rsp_ready pulse after reset release.

## Configuration
- GPIO_DI_SYNC_EN defined: gpio_di passes through a 2-flop synchronizer, so pin-to-readable latency is 2 cycles.
- GPIO_DI_SYNC_EN undefined: a single register stage, so latency is 1 cycle.

## Structure
- Package gpio_local_ram_pkg holds:
  - GPIO_PAGE = 20'hF0000.
  - Offsets GPIO_DO_OFS = 12'h000, GPIO_OE_OFS = 12'h004, GPIO_DI_OFS = 12'h008.
- One sub-module, gpio_local_ram_mem: WORDS-deep, byte-enable write, registered-read RAM with inference-friendly coding.
- GPIO registers and the decode/mux live in the top.

## Test plan
- Reset, then idle: gpio_oe = 0, gpio_do = 0, mem_rsp_ready = 0, mem_cmd_ready = 1.
- RAM byte enables:
  - Write 0x11223344 to 0x100 with be = 4'hF, then write 0xAABBCCDD with be = 4'b0101.
  - Read 0x100: rsp_ready exactly 2 cycles later with 0x11BB33DD.
- GPIO outputs:
  - Write 0xA5 to 0xF0000000 and 0x0F to 0xF0000004.
  - gpio_do = 0xA5 and gpio_oe = 0x0F next cycle.
  - Read-back returns 0x000000A5 / 0x0000000F, 1 cycle after command.
- GPIO input: drive gpio_di = 0x3C, wait 3 cycles, read 0xF0000008 → 0x0000003C. Repeat with and without GPIO_DI_SYNC_EN.
- Void and edge addresses:
  - Read 0x80000000 → 0 after 1 cycle.
  - Write 0x12345678 to 0x2000 (first address past 8 KiB), then read RAM 0x0 → word 0 unchanged.
- Overlap: read RAM 0x100, and in the next cycle write GPIO DO = 0x01. The single rsp_ready arrives at N+2 with RAM data, and gpio_do = 0x01.

Source files
------------

// File: rtl/gpio_local_ram_pkg.sv
// Shared constants for the local RAM / GPIO peripheral: GPIO page address,
// register offsets and the decoded target type.
package gpio_local_ram_pkg;

  localparam logic [19:0] GPIO_PAGE   = 20'hF0000;
  localparam logic [11:0] GPIO_DO_OFS = 12'h000;
  localparam logic [11:0] GPIO_OE_OFS = 12'h004;
  localparam logic [11:0] GPIO_DI_OFS = 12'h008;

  typedef enum logic [1:0] {
    TGT_VOID = 2'd0,
    TGT_RAM  = 2'd1,
    TGT_GPIO = 2'd2
  } target_e;

endpackage

// File: rtl/gpio_local_ram_mem.sv
// Single-port, byte-writable, registered-read RAM of WORDS 32-bit words.
// Coded so synthesis maps it onto block RAM with byte-write enables.
module gpio_local_ram_mem #(
  parameter int WORDS = 2048,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/gpio_local_ram.sv
// Local RAM plus GPIO port behind one address decoder and OR-combined read
// response. Define GPIO_DI_SYNC_EN for a 2-flop synchronizer on gpio_di.
module gpio_local_ram
  import gpio_local_ram_pkg::*;
#(
  parameter int LOCAL_RAM_SIZE_KB = 8,
  parameter int NR_GPIOS          = 8
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                mem_cmd_valid,
  output logic                mem_cmd_ready,
  input  logic                mem_cmd_wr,
  input  logic [31:0]         mem_cmd_addr,
  input  logic [31:0]         mem_cmd_wdata,
  input  logic [3:0]          mem_cmd_be,
  output logic                mem_rsp_ready,
  output logic [31:0]         mem_rsp_rdata,
  output logic [NR_GPIOS-1:0] gpio_oe,
  output logic [NR_GPIOS-1:0] gpio_do,
  input  logic [NR_GPIOS-1:0] gpio_di
);

  localparam int WORDS = LOCAL_RAM_SIZE_KB * 256;
  localparam int AW    = $clog2(WORDS);

  target_e       tgt;
  logic [11:0]   ofs;
  logic          ram_en;
  logic          gpio_wr;
  logic          fast_rd_p0;
  logic          gpio_rd_p0;
  logic [31:0]   gpio_rdata_p0;
  logic [31:0]   ram_rdata_p1;
  logic          ram_vld_p1;
  logic [NR_GPIOS-1:0] do_q;
  logic [NR_GPIOS-1:0] oe_q;
  logic [NR_GPIOS-1:0] di_sync;

  assign mem_cmd_ready = 1'b1;
  assign ofs           = mem_cmd_addr[11:0];

  always_comb begin
    tgt = TGT_VOID;
    if (mem_cmd_addr[31:AW+2] == '0)          tgt = TGT_RAM;
    else if (mem_cmd_addr[31:12] == GPIO_PAGE) tgt = TGT_GPIO;
  end

  assign ram_en     = mem_cmd_valid && (tgt == TGT_RAM);
  assign gpio_wr    = mem_cmd_valid && mem_cmd_wr && (tgt == TGT_GPIO);
  assign gpio_rd_p0 = mem_cmd_valid && !mem_cmd_wr && (tgt == TGT_GPIO);
  // GPIO and void reads both answer after one cycle; void just contributes no data.
  assign fast_rd_p0 = mem_cmd_valid && !mem_cmd_wr && (tgt != TGT_RAM);

  gpio_local_ram_mem #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .en    (ram_en),
    .we    (mem_cmd_wr),
    .addr  (mem_cmd_addr[AW+1:2]),
    .be    (mem_cmd_be),
    .wdata (mem_cmd_wdata),
    .rdata (ram_rdata_p1)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      do_q <= '0;
      oe_q <= '0;
    end else if (gpio_wr) begin
      if (ofs == GPIO_DO_OFS) do_q <= mem_cmd_wdata[NR_GPIOS-1:0];
      if (ofs == GPIO_OE_OFS) oe_q <= mem_cmd_wdata[NR_GPIOS-1:0];
    end
  end

  assign gpio_do = do_q;
  assign gpio_oe = oe_q;

`ifdef GPIO_DI_SYNC_EN
  logic [NR_GPIOS-1:0] di_meta;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      di_meta <= '0;
      di_sync <= '0;
    end else begin
      di_meta <= gpio_di;
      di_sync <= di_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) di_sync <= '0;
    else         di_sync <= gpio_di;
  end
`endif

  always_comb begin
    gpio_rdata_p0 = '0;
    case (ofs)
      GPIO_DO_OFS: gpio_rdata_p0[NR_GPIOS-1:0] = do_q;
      GPIO_OE_OFS: gpio_rdata_p0[NR_GPIOS-1:0] = oe_q;
      GPIO_DI_OFS: gpio_rdata_p0[NR_GPIOS-1:0] = di_sync;
      default:     gpio_rdata_p0 = '0;
    endcase
  end

  // p0 -> p1: RAM array read in flight
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) ram_vld_p1 <= 1'b0;
    else         ram_vld_p1 <= ram_en && !mem_cmd_wr;
  end

  // p1 -> output: each target's data gated by its own ready, then OR-combined
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      mem_rsp_ready <= 1'b0;
      mem_rsp_rdata <= '0;
    end else begin
      mem_rsp_ready <= ram_vld_p1 || fast_rd_p0;
      mem_rsp_rdata <= ({32{ram_vld_p1}} & ram_rdata_p1) |
                       ({32{gpio_rd_p0}} & gpio_rdata_p0);
    end
  end

endmodule

// File: tb/tb_gpio_local_ram.sv
// Randomized self-checking bench for gpio_local_ram against a decode-level
// reference model (array RAM, GPIO register values, latency per target).
module tb_gpio_local_ram;

  localparam int KB    = 8;
  localparam int NG    = 8;
  localparam int WORDS = KB * 256;

  logic          clk = 1'b0;
  logic          reset_;
  logic          mem_cmd_valid;
  logic          mem_cmd_ready;
  logic          mem_cmd_wr;
  logic [31:0]   mem_cmd_addr;
  logic [31:0]   mem_cmd_wdata;
  logic [3:0]    mem_cmd_be;
  logic          mem_rsp_ready;
  logic [31:0]   mem_rsp_rdata;
  logic [NG-1:0] gpio_oe;
  logic [NG-1:0] gpio_do;
  logic [NG-1:0] gpio_di;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0]   ram_m [WORDS];
  logic [NG-1:0] do_m;
  logic [NG-1:0] oe_m;
  logic [NG-1:0] di_m;

  gpio_local_ram #(
    .LOCAL_RAM_SIZE_KB (KB),
    .NR_GPIOS          (NG)
  ) dut (
    .clk           (clk),
    .reset_        (reset_),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_wr    (mem_cmd_wr),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_wdata (mem_cmd_wdata),
    .mem_cmd_be    (mem_cmd_be),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_rdata (mem_rsp_rdata),
    .gpio_oe       (gpio_oe),
    .gpio_do       (gpio_do),
    .gpio_di       (gpio_di)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] zext(input logic [NG-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NG-1:0] = v;
    return r;
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'(KB * 1024);
  endfunction

  function automatic bit is_gpio(input logic [31:0] a);
    return a[31:12] == 20'hF0000;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (is_ram(a)) return ram_m[a >> 2];
    if (is_gpio(a)) begin
      case (a[11:0])
        12'h000: return zext(do_m);
        12'h004: return zext(oe_m);
        12'h008: return zext(di_m);
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  function automatic int model_lat(input logic [31:0] a);
    return is_ram(a) ? 2 : 1;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    if (is_ram(a)) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) ram_m[a >> 2][8*i +: 8] = d[8*i +: 8];
    end else if (is_gpio(a)) begin
      if (a[11:0] == 12'h000) do_m = d[NG-1:0];
      if (a[11:0] == 12'h004) oe_m = d[NG-1:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for exactly one clock edge; returns 1ns into cycle N+1.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    mem_cmd_valid = 1'b1;
    mem_cmd_wr    = wr;
    mem_cmd_addr  = a;
    mem_cmd_wdata = d;
    mem_cmd_be    = b;
    step();
    mem_cmd_valid = 1'b0;
    mem_cmd_wr    = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_wdata = '0;
    mem_cmd_be    = '0;
  endtask

  task automatic wr_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    issue(1'b1, a, d, b);
    model_write(a, d, b);
    check("gpio_do", zext(gpio_do), zext(do_m));
    check("gpio_oe", zext(gpio_oe), zext(oe_m));
  endtask

  task automatic rd_cmd(input string tag, input logic [31:0] a);
    logic [31:0] exp;
    int lat;
    exp = model_read(a);
    lat = model_lat(a);
    issue(1'b0, a, 32'h0, 4'h0);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) step();
      if (k < lat) begin
        check({tag, "_early"}, 32'(mem_rsp_ready), 32'h0);
      end else begin
        check({tag, "_rdy"}, 32'(mem_rsp_ready), 32'h1);
        check({tag, "_data"}, mem_rsp_rdata, exp);
      end
    end
    step();
    check({tag, "_pulse"}, 32'(mem_rsp_ready), 32'h0);
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] a;
    reset_        = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_wr    = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_wdata = '0;
    mem_cmd_be    = '0;
    gpio_di       = '0;
    do_m = '0;
    oe_m = '0;
    di_m = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_oe", zext(gpio_oe), 32'h0);
    check("rst_do", zext(gpio_do), 32'h0);
    check("rst_rsp_ready", 32'(mem_rsp_ready), 32'h0);
    check("rst_rsp_rdata", mem_rsp_rdata, 32'h0);
    check("cmd_ready", 32'(mem_cmd_ready), 32'h1);
    reset_ = 1'b1;
    repeat (2) step();
    check("idle_rsp_ready", 32'(mem_rsp_ready), 32'h0);

    // RAM byte enables
    wr_cmd(32'h100, 32'h11223344, 4'hF);
    wr_cmd(32'h100, 32'hAABBCCDD, 4'b0101);
    check("be_model", model_read(32'h100), 32'h11BB33DD);
    rd_cmd("ram_be", 32'h100);
    wr_cmd(32'h104, 32'hDEADBEEF, 4'h0);
    wr_cmd(32'h104, 32'h01020304, 4'b1000);
    ram_m[32'h104 >> 2] = 32'h01xxxxxx;
    // Word 0x104 only has its top byte defined; rewrite fully for a clean read.
    wr_cmd(32'h104, 32'h5566_7788, 4'hF);
    rd_cmd("ram_full", 32'h104);

    // GPIO outputs
    wr_cmd(32'hF0000000, 32'h000000A5, 4'h0);
    wr_cmd(32'hF0000004, 32'hFFFFFF0F, 4'hF);
    check("gpio_do_a5", zext(gpio_do), 32'hA5);
    check("gpio_oe_0f", zext(gpio_oe), 32'h0F);
    rd_cmd("gpio_do_rd", 32'hF0000000);
    rd_cmd("gpio_oe_rd", 32'hF0000004);
    rd_cmd("gpio_hole", 32'hF000000C);
    wr_cmd(32'hF0000008, 32'hFF, 4'hF);

    // GPIO input
    gpio_di = 8'h3C;
    di_m    = 8'h3C;
    repeat (3) step();
    rd_cmd("gpio_di", 32'hF0000008);

    // Void and edge addresses
    rd_cmd("void_rd", 32'h80000000);
    wr_cmd(32'h0, 32'hCAFEF00D, 4'hF);
    wr_cmd(32'h2000, 32'h12345678, 4'hF);
    rd_cmd("ram_edge", 32'h0);
    rd_cmd("ram_last", 32'h100);

    // Overlap: RAM read then GPIO write while it is outstanding
    exp = model_read(32'h100);
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    check("ovl_early", 32'(mem_rsp_ready), 32'h0);
    issue(1'b1, 32'hF0000000, 32'h01, 4'hF);
    model_write(32'hF0000000, 32'h01, 4'hF);
    check("ovl_rdy", 32'(mem_rsp_ready), 32'h1);
    check("ovl_data", mem_rsp_rdata, exp);
    check("ovl_do", zext(gpio_do), 32'h01);
    step();
    check("ovl_pulse", 32'(mem_rsp_ready), 32'h0);

    // Reset during an outstanding RAM read drops the response
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    reset_ = 1'b0;
    do_m = '0;
    oe_m = '0;
    step();
    check("rst_mid_rdy", 32'(mem_rsp_ready), 32'h0);
    reset_ = 1'b1;
    step();
    check("rst_mid_rdy1", 32'(mem_rsp_ready), 32'h0);
    step();
    check("rst_mid_rdy2", 32'(mem_rsp_ready), 32'h0);
    check("rst_mid_do", zext(gpio_do), 32'h0);
    repeat (2) step();

    // Randomized traffic over a pre-initialised RAM window, GPIO and void space
    for (int w = 0; w < 64; w++) wr_cmd(32'(w * 4), $urandom, 4'hF);
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: wr_cmd(32'($urandom_range(0, 63) * 4), $urandom, 4'($urandom_range(0, 15)));
        1: rd_cmd("rnd_ram", 32'($urandom_range(0, 63) * 4));
        2: wr_cmd({20'hF0000, 8'h0, 2'($urandom_range(0, 3)), 2'b00}, $urandom, 4'($urandom));
        3: rd_cmd("rnd_gpio", {20'hF0000, 8'h0, 2'($urandom_range(0, 3)), 2'b00});
        4: begin
          a = {1'b1, 29'($urandom), 2'b00};
          if ($urandom_range(0, 1) == 1) wr_cmd(a, $urandom, 4'hF);
          else rd_cmd("rnd_void", a);
        end
        5: begin
          gpio_di = NG'($urandom);
          di_m    = gpio_di;
          repeat (3) step();
        end
        default: begin
          a = 32'(32'h2000 + $urandom_range(0, 1023) * 4);
          wr_cmd(a, $urandom, 4'hF);
        end
      endcase
    end
    for (int w = 0; w < 64; w++) rd_cmd("final_ram", 32'(w * 4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
